// File: rtl/arbiter_pkg.sv
// Shared arbitration helpers for the tagged round-robin memory arbiter.
// Pure combinational functions, no state.
package arbiter_pkg;

    localparam int MAX_N = 32;

    // Returns the first valid index scanning from ptr upward, wrapping at n.
    function automatic int unsigned rr_pick(
        input logic [MAX_N-1:0] valid,
        input int unsigned      ptr,
        input int unsigned      n
    );
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            idx = (ptr + k) % n;
            if (k < n && !found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/arbiter_tag_fifo.sv
// In-order requester-tag FIFO; push/pop take effect at the clock edge, dout shows the head.
// No backpressure of its own: pushes when full and pops when empty are ignored.
module arbiter_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    generate
        if (DEPTH == 1) begin : g_single
            logic [WIDTH-1:0] data_q;
            logic             vld_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q <= 1'b0;
                end else if (push && !vld_q) begin
                    vld_q <= 1'b1;
                end else if (pop && vld_q) begin
                    vld_q <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (push && !vld_q) begin
                    data_q <= din;
                end
            end

            assign dout  = data_q;
            assign empty = ~vld_q;
            assign full  = vld_q;
            assign count = CW'(vld_q);
        end else begin : g_ring
            localparam int PW = $clog2(DEPTH);

            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PW-1:0]    wr_ptr, rd_ptr;
            logic [CW-1:0]    cnt_q;
            logic             do_push, do_pop;

            assign empty   = (cnt_q == '0);
            assign full    = (cnt_q == CW'(DEPTH));
            assign do_push = push && !full;
            assign do_pop  = pop && !empty;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt_q  <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + PW'(1);
                    if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
                    case ({do_push, do_pop})
                        2'b10:   cnt_q <= cnt_q + CW'(1);
                        2'b01:   cnt_q <= cnt_q - CW'(1);
                        default: cnt_q <= cnt_q;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (do_push) begin
                    mem_q[wr_ptr] <= din;
                end
            end

            assign dout  = mem_q[rd_ptr];
            assign count = cnt_q;
        end
    endgenerate

endmodule

// File: rtl/memory_arbiter_rr_tagged.sv
// Round-robin read arbiter with in-order tag routing; issue and response are both 0-cycle combinational.
// Backpressure: mem_ready low or MAX_OUTSTANDING in flight holds all req_ready low; responses cannot be stalled.
module memory_arbiter_rr_tagged
    import arbiter_pkg::*;
#(
    parameter int N               = 2,
    parameter int ADDR_WIDTH      = 11,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      req_valid,
    input  logic [N*ADDR_WIDTH-1:0]           req_addr,
    output logic [N-1:0]                      req_ready,
    output logic [N-1:0]                      resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic                              mem_valid,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic                              mem_ready,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_orphan
);

    localparam int ID_BITS = $clog2(N);

    logic [ID_BITS-1:0] ptr, winner, head_tag;
    logic               any_req, full, empty, issue, pop;

    assign any_req   = |req_valid;
    assign winner    = ID_BITS'(rr_pick(MAX_N'(req_valid), 32'(ptr), 32'(N)));
    // A pop in the same cycle does not free a slot: keeps full off the response path.
    assign mem_valid = any_req & ~full;
    assign issue     = mem_valid & mem_ready;
    assign mem_addr  = any_req ? req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign req_ready = issue ? (N'(1) << winner) : '0;

    assign pop        = mem_rvalid & ~empty;
    assign resp_valid = pop ? (N'(1) << head_tag) : '0;
    assign resp_data  = pop ? mem_rdata : '0;

    arbiter_tag_fifo #(
        .WIDTH (ID_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .din   (winner),
        .pop   (pop),
        .dout  (head_tag),
        .empty (empty),
        .full  (full),
        .count (outstanding)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue) begin
                ptr <= (winner == ID_BITS'(N - 1)) ? '0 : winner + ID_BITS'(1);
            end
            if (mem_rvalid && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule
